// File: rtl/y86_pkg.sv
// Shared Y86 fetch definitions: icode constants, fetch state encoding, word type.
package y86_pkg;
    typedef logic [63:0] word_t;
    typedef logic [3:0]  icode_t;

    localparam icode_t HALT = 4'h0;
    localparam icode_t NOP  = 4'h1;
    localparam icode_t JXX  = 4'h7;
    localparam icode_t CALL = 4'h8;
    localparam icode_t RET  = 4'h9;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage predicted-PC bus: M/W correction inputs, fetch decoder results, PC outputs.
interface fetch_pc_ctrl_if #(
    parameter int CNT_W = 32
);
    import y86_pkg::*;

    logic             F_stall;
    icode_t           M_icode;
    logic             M_Cnd;
    word_t            M_valA;
    icode_t           W_icode;
    word_t            W_valM;
    icode_t           f_icode;
    word_t            f_valC;
    word_t            f_valP;
    logic             f_imem_error;
    logic             f_instr_valid;
    word_t            f_pc;
    word_t            F_predPC;
    logic             f_hold;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] redirect_count;

    modport master (
        input  F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM,
        input  f_icode, f_valC, f_valP, f_imem_error, f_instr_valid,
        output f_pc, F_predPC, f_hold, fetch_count, redirect_count
    );

    modport slave (
        output F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM,
        output f_icode, f_valC, f_valP, f_imem_error, f_instr_valid,
        input  f_pc, F_predPC, f_hold, fetch_count, redirect_count
    );
endinterface

// File: rtl/fetch_pred.sv
// Pure combinational next-PC prediction and stop detection for a fetched instruction.
module fetch_pred
    import y86_pkg::*;
(
    input  icode_t i_icode,
    input  word_t  i_valC,
    input  word_t  i_valP,
    input  logic   i_imem_error,
    input  logic   i_instr_valid,
    output word_t  o_pred_pc,
    output logic   o_stop
);
    // Jumps are predicted taken; calls always go to their target.
    assign o_pred_pc = (i_icode == JXX || i_icode == CALL) ? i_valC : i_valP;
    assign o_stop    = (i_icode == HALT) || i_imem_error || !i_instr_valid;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC select and F_predPC register with RUN/HOLD parking on halt/error.
// Optional saturating fetch/redirect counters enabled by macro FETCH_CNT_EN.
//   state  | meaning
//   S_RUN  | fetching normally, F_predPC follows prediction
//   S_HOLD | parked on halt/bad instruction until M/W redirect
module fetch_pc_ctrl
    import y86_pkg::*;
#(
    parameter word_t RESET_PC = 64'h0,
    parameter int    CNT_W    = 32
)(
    input  logic            clk,
    input  logic            reset,
    fetch_pc_ctrl_if.master bus
);
    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    word_t        r_predpc;
    word_t        w_predpc_nxt;
    word_t        w_f_pc;
    word_t        w_pred_pc;
    logic         w_stop;
    logic         w_mispredict;
    logic         w_ret;
    logic         w_redirect;
    logic         w_run_rules;

    // Mispredict in M is younger than the ret in W, so it wins.
    assign w_mispredict = (bus.M_icode == JXX) && !bus.M_Cnd;
    assign w_ret        = (bus.W_icode == RET);
    assign w_redirect   = w_mispredict || w_ret;
    assign w_f_pc       = w_mispredict ? bus.M_valA :
                          w_ret        ? bus.W_valM : r_predpc;

    fetch_pred u_pred (
        .i_icode       (bus.f_icode),
        .i_valC        (bus.f_valC),
        .i_valP        (bus.f_valP),
        .i_imem_error  (bus.f_imem_error),
        .i_instr_valid (bus.f_instr_valid),
        .o_pred_pc     (w_pred_pc),
        .o_stop        (w_stop)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_predpc_nxt = r_predpc;
        w_run_rules  = 1'b0;
        case (r_state)
            S_RUN:   w_run_rules = 1'b1;
            S_HOLD:  w_run_rules = w_redirect;
            default: w_run_rules = 1'b1;
        endcase
        if (w_run_rules) begin
            if (w_stop) begin
                // Re-fetch the stopping instruction on every parked cycle.
                w_predpc_nxt = w_f_pc;
                w_state_nxt  = S_HOLD;
            end else begin
                w_predpc_nxt = w_pred_pc;
                w_state_nxt  = S_RUN;
            end
        end else begin
            w_predpc_nxt = w_f_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_predpc <= RESET_PC;
        end else if (!bus.F_stall) begin
            r_state  <= w_state_nxt;
            r_predpc <= w_predpc_nxt;
        end
    end

    assign bus.f_pc     = w_f_pc;
    assign bus.F_predPC = r_predpc;
    assign bus.f_hold   = (r_state == S_HOLD);

`ifdef FETCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_fetch_count;
    logic [CNT_W-1:0] r_redirect_count;
    logic             w_fetch_inc;

    assign w_fetch_inc = (r_state == S_RUN) && !w_stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count    <= '0;
            r_redirect_count <= '0;
        end else if (!bus.F_stall) begin
            if (w_fetch_inc && (r_fetch_count != '1))
                r_fetch_count <= r_fetch_count + CNT_ONE;
            if (w_redirect && (r_redirect_count != '1))
                r_redirect_count <= r_redirect_count + CNT_ONE;
        end
    end

    assign bus.fetch_count    = r_fetch_count;
    assign bus.redirect_count = r_redirect_count;
`else
    assign bus.fetch_count    = {CNT_W{1'b0}};
    assign bus.redirect_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed plan followed by randomized traffic.
module tb_fetch_pc_ctrl;
    import y86_pkg::*;

    typedef struct {
        logic [63:0] fpc;
        logic [63:0] pred;
        logic        hold;
        logic [31:0] fc;
        logic [31:0] rc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    fetch_pc_ctrl_if #(.CNT_W(32)) bus ();

    fetch_pc_ctrl #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // stimulus staging
    logic        s_reset, s_stall, s_mcnd, s_err, s_valid;
    logic [3:0]  s_micode, s_wicode, s_ficode;
    logic [63:0] s_mvala, s_wvalm, s_valc, s_valp;

    // reference model state
    logic [63:0] m_pred;
    logic        m_parked;
    logic [31:0] m_fc, m_rc;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("f_pc", bus.f_pc, e.fpc);
            chk("F_predPC", bus.F_predPC, e.pred);
            chk("f_hold", {63'b0, bus.f_hold}, {63'b0, e.hold});
            chk("fetch_count", {32'b0, bus.fetch_count}, {32'b0, e.fc});
            chk("redirect_count", {32'b0, bus.redirect_count}, {32'b0, e.rc});
        end
    end

    task automatic apply();
        reset             = s_reset;
        bus.F_stall       = s_stall;
        bus.M_icode       = s_micode;
        bus.M_Cnd         = s_mcnd;
        bus.M_valA        = s_mvala;
        bus.W_icode       = s_wicode;
        bus.W_valM        = s_wvalm;
        bus.f_icode       = s_ficode;
        bus.f_valC        = s_valc;
        bus.f_valP        = s_valp;
        bus.f_imem_error  = s_err;
        bus.f_instr_valid = s_valid;
    endtask

    function automatic logic [63:0] sel_pc();
        if (s_micode == 4'h7 && !s_mcnd) return s_mvala;
        if (s_wicode == 4'h9)            return s_wvalm;
        return m_pred;
    endfunction

    task automatic model_update();
        logic [63:0] target;
        logic        redirect, stopped;
        target   = sel_pc();
        redirect = (s_micode == 4'h7 && !s_mcnd) || (s_wicode == 4'h9);
        stopped  = (s_ficode == 4'h0) || s_err || !s_valid;
        if (s_reset) begin
            m_pred = 64'h0; m_parked = 1'b0; m_fc = 0; m_rc = 0;
        end else if (!s_stall) begin
            if (!m_parked && !stopped && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (redirect && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
            if (!m_parked || redirect) begin
                if (stopped) begin
                    m_pred = target; m_parked = 1'b1;
                end else begin
                    m_pred = (s_ficode == 4'h7 || s_ficode == 4'h8) ? s_valc : s_valp;
                    m_parked = 1'b0;
                end
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.fpc  = sel_pc();
        e.pred = m_pred;
        e.hold = m_parked;
`ifdef FETCH_CNT_EN
        e.fc = m_fc;
        e.rc = m_rc;
`else
        e.fc = 32'h0;
        e.rc = 32'h0;
`endif
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply();
        push_expect();
        model_update();
    endtask

    task automatic quiet();
        s_reset = 0; s_stall = 0; s_micode = NOP; s_mcnd = 1'b1; s_mvala = 64'h0;
        s_wicode = NOP; s_wvalm = 64'h0; s_ficode = NOP; s_valc = 64'h0;
        s_valp = 64'h0; s_err = 0; s_valid = 1;
    endtask

    function automatic logic [3:0] pick_icode(input int bias_code);
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 4'(bias_code);
        if (r == 1) return NOP;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic random_step();
        s_reset  = ($urandom_range(0, 39) == 0);
        s_stall  = ($urandom_range(0, 4) == 0);
        s_micode = pick_icode(JXX);
        s_mcnd   = 1'($urandom_range(0, 1));
        s_mvala  = {$urandom, $urandom};
        s_wicode = ($urandom_range(0, 5) == 0) ? RET : pick_icode(NOP);
        s_wvalm  = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0:       s_ficode = HALT;
            1, 2:    s_ficode = JXX;
            3, 4:    s_ficode = CALL;
            5, 6:    s_ficode = NOP;
            default: s_ficode = 4'($urandom_range(1, 15));
        endcase
        s_valc  = {$urandom, $urandom};
        s_valp  = {$urandom, $urandom};
        s_err   = ($urandom_range(0, 19) == 0);
        s_valid = ($urandom_range(0, 19) != 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        s_reset = 1;
        apply();
        model_update();
        step();                                    // second reset cycle
        s_reset = 0; s_ficode = NOP; s_valp = 64'h1;
        step();
        s_ficode = CALL; s_valc = 64'h40;
        step();
        s_ficode = JXX; s_valc = 64'h80;
        step();
        // mispredict and ret together
        s_ficode = NOP; s_valp = 64'h14;
        s_micode = JXX; s_mcnd = 0; s_mvala = 64'h13;
        s_wicode = RET; s_wvalm = 64'h99;
        step();
        quiet();
        s_ficode = NOP; s_valp = 64'h15;
        step();
        for (int i = 0; i < 3; i++) begin
            s_stall = 1; s_valp = 64'h100 + 64'(i);
            s_micode = (i == 1) ? JXX : NOP; s_mcnd = 0; s_mvala = 64'h555;
            step();
        end
        quiet();
        s_ficode = CALL; s_valc = 64'h20;
        step();
        s_ficode = HALT; s_valp = 64'h21;
        step();
        for (int i = 0; i < 5; i++) begin
            s_ficode = NOP; s_valp = 64'h700 + 64'(i);
            step();
        end
        s_wicode = RET; s_wvalm = 64'h30; s_ficode = NOP; s_valp = 64'h31;
        step();
        quiet();
        s_ficode = NOP; s_valp = 64'h32;
        step();
        // reset while parked
        s_ficode = HALT;
        step();
        s_ficode = NOP; s_reset = 1;
        step();
        s_reset = 0; s_valp = 64'h44;
        step();
        // reset while stalled
        s_stall = 1; s_reset = 1;
        step();
        s_stall = 0; s_reset = 0; s_valp = 64'h50;
        step();
        for (int i = 0; i < 400; i++) random_step();
        quiet();
        step();
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, 0 required", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Producer side of the fetch-stage predicted-PC interface.
- Owns the F pipeline register (F_predPC) and selects the fetch address f_pc from three sources: the M-stage mispredict correction, the W-stage return target, or the prediction.
- Computes the next predicted PC and updates F_predPC, honouring F_stall from pipeline control.
- Parks fetch on halt or error instructions until a redirect arrives.

Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.
- CNT_W, 32, width of the optional fetch counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- F_stall  input  1  from pipeline control; when 1, all state holds.
- M_icode  input  4  icode in M stage.
- M_Cnd  input  1  branch condition result in M stage.
- M_valA  input  64  fall-through PC of the jXX in M.
- W_icode  input  4  icode in W stage.
- W_valM  input  64  return address popped by ret in W.
- f_icode  input  4  icode of the instruction fetched at f_pc.
- f_valC  input  64  constant word of the fetched instruction.
- f_valP  input  64  address of the next sequential instruction.
- f_imem_error  input  1  instruction memory error at f_pc.
- f_instr_valid  input  1  fetched icode is legal.
- f_pc  output  64  selected fetch address (combinational).
- F_predPC  output  64  registered predicted PC.
- f_hold  output  1  1 while fetch is parked in state HOLD.
- fetch_count  output  CNT_W  instructions accepted; see Optional Feature.
- redirect_count  output  CNT_W  redirects taken; see Optional Feature.

Behaviour:
- f_pc, combinational, in priority order:
  - (M_icode==JXX && !M_Cnd) -> M_valA;
  - else W_icode==RET -> W_valM;
  - else F_predPC.
- "redirect" = either of the first two conditions.
- pred_pc, combinational: f_icode in {JXX, CALL} -> f_valC; else f_valP.
- "stop" = (f_icode==HALT) || f_imem_error || !f_instr_valid.
- State machine, states RUN and HOLD; every update at posedge clk.
- reset=1 (highest priority; legal mid-operation or mid-stall): F_predPC<=RESET_PC, state<=RUN. f_hold=0 and both counters=0 in the following cycle.
- else F_stall=1: F_predPC, state and counters hold. Stall beats a simultaneous redirect; the redirect is taken on the first unstalled cycle, since M/W are held by control.
- RUN:
  - stop=0: F_predPC<=pred_pc.
  - stop=1: F_predPC<=f_pc, so the halt/bad instruction is re-fetched; state<=HOLD.
- HOLD:
  - redirect=1: apply RUN rules to the instruction at the redirect target; state<=RUN, or stays HOLD if that instruction also has stop=1.
  - redirect=0: F_predPC<=f_pc, which equals the old F_predPC.
- f_hold = (state==HOLD).
- Latency: F_predPC reflects a fetch one cycle after that fetch.
- Arithmetic: no PC arithmetic inside the block; valP comes from the fetch decoder. 64-bit values wrap naturally. f_pc is treated as unsigned.
- Simultaneous mispredict in M and ret in W: mispredict wins (younger correction).

Optional Feature:
- Macro FETCH_CNT_EN.
- When defined, both counters are reset to 0, hold under F_stall, and saturate at all-ones:
  - fetch_count +1 on each unstalled cycle with state==RUN and stop=0;
  - redirect_count +1 on each unstalled cycle with redirect=1.
- When undefined, both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package y86_pkg: icode constants HALT=4'h0, NOP=4'h1, JXX=4'h7, CALL=4'h8, RET=4'h9; state enum {RUN, HOLD}; 64-bit word typedef.
- One sub-module, fetch_pred: the pure combinational pred_pc and stop logic. Reusable by the fetch decoder checker.

Test Plan:
- Reset: assert reset 2 cycles -> F_predPC=0, f_pc=0, f_hold=0, counters 0. Then f_icode=NOP, f_valP=1 -> F_predPC=1 next cycle.
- Predict: f_icode=CALL, f_valC=0x40 -> F_predPC=0x40. Then f_icode=JXX, f_valC=0x80 -> F_predPC=0x80.
- Mispredict: M_icode=JXX, M_Cnd=0, M_valA=0x13 with W_icode=RET, W_valM=0x99 -> f_pc=0x13 (mispredict wins); redirect_count+1 with FETCH_CNT_EN.
- Stall: F_stall=1 for 3 cycles while f_valP changes -> F_predPC constant, counters constant. Then deassert -> resumes from pred_pc.
- Halt: f_icode=HALT at 0x20 -> f_hold=1, F_predPC stays 0x20 for 5 cycles. Then W_icode=RET, W_valM=0x30, f_icode=NOP, f_valP=0x31 -> F_predPC=0x31, f_hold=0.
- Reset mid-HOLD and mid-stall -> state RUN, F_predPC=RESET_PC the next cycle.
